// File: rtl/mul_pkg.sv
// ============================================================================
// Module  : mul_pkg
// Brief   : Shared state encoding, widths and operand-extension helper for the
//           iterative radix-4 Booth multiplier sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int MUL_STEPS = 17;
  localparam int MUL_XW    = 66;
  localparam int MUL_OPW   = 32;
  localparam int MUL_YW    = 2 * MUL_STEPS + 1;
  localparam int MUL_CNTW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // 33-bit extension: the extra MSB is a sign copy only for signed operations.
  function automatic logic [MUL_OPW:0] mul_ext33(input logic sgn,
                                                 input logic [MUL_OPW-1:0] v);
    return {sgn & v[MUL_OPW-1], v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_booth_iter_ctrl.sv
// ============================================================================
// Module  : mul_booth_iter_ctrl
// Brief   : IDLE/BUSY/DONE sequencer, step counter and (with MUL_EARLY_TERM_EN)
//           detection of a multiplier window whose remaining triplets are zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_booth_iter_ctrl
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
`ifdef MUL_EARLY_TERM_EN
  input  logic [MUL_YW-1:0] y_win,
`endif
  input  logic              in_valid,
  input  logic              cancel,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              out_valid,
  output logic              load,
  output logic              step_en
);

  mul_state_e          state_q, state_d;
  logic [MUL_CNTW-1:0] step_q, step_d;
  logic                last_step;

  assign last_step = (step_q == MUL_CNTW'(MUL_STEPS - 1));

`ifdef MUL_EARLY_TERM_EN
  // Y is shifted arithmetically, so the live window is uniform exactly when
  // the whole register is all-0 or all-1.
  logic y_uniform;
  assign y_uniform = (y_win == '0) || (&y_win);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load    = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !cancel) begin
          load    = 1'b1;
          state_d = BUSY;
          step_d  = '0;
        end
      end
      BUSY: begin
        if (cancel) begin
          state_d = IDLE;
        end
`ifdef MUL_EARLY_TERM_EN
        else if (y_uniform) begin
          state_d = DONE;
        end
`endif
        else begin
          step_en = 1'b1;
          if (last_step) begin
            state_d = DONE;
          end else begin
            step_d = step_q + MUL_CNTW'(1);
          end
        end
      end
      DONE: begin
        if (cancel || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule

`default_nettype wire

// File: rtl/mul_booth_iter.sv
// ============================================================================
// Module  : mul_booth_iter
// Brief   : Iterative radix-4 Booth multiplier sequencer around an external
//           66-bit partial-product cell. Optional macro MUL_EARLY_TERM_EN
//           finishes as soon as the remaining multiplier triplets are zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_booth_iter
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [MUL_OPW-1:0]   in_src1,
  input  logic [MUL_OPW-1:0]   in_src2,
  input  logic                 cancel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*MUL_OPW-1:0] out_result,
  output logic                 bth_y2,
  output logic                 bth_y1,
  output logic                 bth_y0,
  output logic [MUL_XW-1:0]    bth_x,
  input  logic [MUL_XW-1:0]    bth_p,
  input  logic                 bth_c
);

  logic [MUL_XW-1:0] x_q, x_d;
  logic [MUL_YW-1:0] y_q, y_d;
  logic [MUL_XW-1:0] acc_q, acc_d;
  logic [MUL_OPW:0]  a33, b33;
  logic              load;
  logic              step_en;
  logic              acc_hi_unused;

  mul_booth_iter_ctrl u_ctrl (
    .clk       (clk),
    .resetn    (resetn),
`ifdef MUL_EARLY_TERM_EN
    .y_win     (y_q),
`endif
    .in_valid  (in_valid),
    .cancel    (cancel),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .load      (load),
    .step_en   (step_en)
  );

  assign a33 = mul_ext33(in_signed, in_src1);
  assign b33 = mul_ext33(in_signed, in_src2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

  // Y carries a guard zero at bit 0 so the first triplet is {b1,b0,0}.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    if (load) begin
      x_d   = {{(MUL_XW-MUL_OPW-1){a33[MUL_OPW]}}, a33};
      y_d   = {b33[MUL_OPW], b33, 1'b0};
      acc_d = '0;
    end else if (step_en) begin
      acc_d = acc_q + bth_p + {{(MUL_XW-1){1'b0}}, bth_c};
      x_d   = {x_q[MUL_XW-3:0], 2'b00};
      y_d   = {y_q[MUL_YW-1], y_q[MUL_YW-1], y_q[MUL_YW-1:2]};
    end
  end

  assign bth_y2 = y_q[2];
  assign bth_y1 = y_q[1];
  assign bth_y0 = y_q[0];
  assign bth_x  = x_q;

  // Only the product is exposed; the two top accumulator bits are wrap-around.
  assign out_result    = out_valid ? acc_q[2*MUL_OPW-1:0] : '0;
  assign acc_hi_unused = ^acc_q[MUL_XW-1:2*MUL_OPW];

endmodule

`default_nettype wire

// File: tb/tb_mul_booth_iter.sv
// ============================================================================
// Module  : tb_mul_booth_iter
// Brief   : Self-checking bench with a behavioural Booth cell, product and
//           latency model, and a queue-based scoreboard monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_booth_iter;

  typedef struct {
    logic [63:0] res;
    int          acc_cyc;
    int          lat;
  } exp_t;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        cancel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        bth_y2, bth_y1, bth_y0;
  logic [65:0] bth_x;
  logic [65:0] bth_p;
  logic        bth_c;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   rnd_bp = 1'b0;
  int   low_left = 0;
  bit   prev_v = 1'b0;
  bit   pend = 1'b0;
  bit   chk_idle = 1'b0;

  mul_booth_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .bth_y2     (bth_y2),
    .bth_y1     (bth_y1),
    .bth_y0     (bth_y0),
    .bth_x      (bth_x),
    .bth_p      (bth_p),
    .bth_c      (bth_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Partial-product cell: p + c == digit * X (mod 2^66), digit = -2*y2 + y1 + y0.
  always_comb begin
    bth_p = '0;
    bth_c = 1'b0;
    case ({bth_y2, bth_y1, bth_y0})
      3'b001, 3'b010: bth_p = bth_x;
      3'b011:         bth_p = bth_x << 1;
      3'b100: begin bth_p = ~(bth_x << 1); bth_c = 1'b1; end
      3'b101, 3'b110: begin bth_p = ~bth_x; bth_c = 1'b1; end
      default: begin bth_p = '0; bth_c = 1'b0; end
    endcase
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2;
    if (s) begin
      sa  = $signed({{32{a[31]}}, a});
      sb2 = $signed({{32{b[31]}}, b});
      return sa * sb2;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Cycles from accept to out_valid: with early termination, the first step
  // whose remaining multiplier window is uniform ends the operation.
  function automatic int exp_lat(input bit s, input logic [31:0] b);
    logic [34:0] y;
    bit          u;
    y = {s & b[31], s & b[31], b, 1'b0};
    if (ET) begin
      for (int i = 0; i < 17; i++) begin
        u = 1'b1;
        for (int k = 2 * i; k < 35; k++) if (y[k] != y[34]) u = 1'b0;
        if (u) return i + 1;
      end
    end
    return 17;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    else if (low_left > 0) begin
      out_ready = 1'b0;
      if (out_valid) low_left--;
    end else out_ready = 1'b1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v   = 1'b0;
      pend     = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) chk("idle_after_hs", 66'(in_ready), 66'd1);
      chk_idle = 1'b0;
      if (pend) chk("valid_held", 66'(out_valid), 66'd1);
      pend = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 66'(out_valid), 66'd0);
        end else begin
          mon_e = sb[0];
          if (!prev_v) chk("latency", 66'(cyc - mon_e.acc_cyc), 66'(mon_e.lat));
          chk("result", 66'(out_result), 66'(mon_e.res));
          chk("in_ready_low", 66'(in_ready), 66'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            chk_idle = 1'b1;
          end else begin
            pend = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_signed = s;
    in_src1   = a;
    in_src2   = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n > 400) break;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 66'(in_ready), 66'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.res     = ref_mul(s, a, b);
      e.acc_cyc = cyc;
      e.lat     = exp_lat(s, b);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 66'(sb.size()), 66'd0);
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 66'(in_ready), 66'd1);
    chk({tag, "_out_valid"}, 66'(out_valid), 66'd0);
    chk({tag, "_out_result"}, 66'(out_result), 66'd0);
    chk({tag, "_bth_x"}, bth_x, 66'd0);
    chk({tag, "_bth_y"}, 66'({bth_y2, bth_y1, bth_y0}), 66'd0);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          s;
    #1 resetn = 1'b0;
    #5 check_reset_vals("reset");
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();

    low_left = 5;
    issue(1'b0, 32'd7, 32'd3, 1'b1);
    drain();

    // Cancel during step 5; nothing may come out.
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_cancel", 66'(in_ready), 66'd0);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_in_ready", 66'(in_ready), 66'd1);
    chk("cancel_out_valid", 66'(out_valid), 66'd0);
    repeat (20) @(posedge clk);
    issue(1'b0, 32'h1234_5678, 32'h0000_0010, 1'b1);
    drain();

    // Asynchronous reset during step 9.
    issue(1'b1, 32'hDEAD_BEEF, 32'h9ABC_DEF1, 1'b0);
    repeat (8) @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk) resetn = 1'b1;
    issue(1'b1, 32'hFFFF_FFFB, 32'd6, 1'b1);
    drain();

    issue(1'b1, 32'd12345, 32'd0, 1'b1);
    issue(1'b1, 32'd3, 32'hFFFF_FFFF, 1'b1);
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 15));
        2: b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
        default: b = -32'($urandom_range(1, 300));
      endcase
      issue(s, a, b, 1'b1);
    end
    drain();
    rnd_bp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
